// File: rtl/riscv_pkg.sv
// Shared constants and response payload type for the instruction-memory fetch arbiter.
package riscv_pkg;

  localparam int unsigned IM_AW = 32;
  localparam int unsigned IM_DW = 32;

  localparam logic [IM_DW-1:0] NOP_INSTR = 32'h00000013;

  localparam int unsigned PORT_F = 0;
  localparam int unsigned PORT_D = 1;

  typedef struct packed {
    logic             valid;
    logic [IM_AW-1:0] addr;
    logic [IM_DW-1:0] data;
    logic             err;
  } im_resp_t;

endpackage

// File: rtl/im_resp_reg.sv
// Per-port response holding register: loads on grant, clears valid when drained.
// Optional misalignment flag and NOP substitution under MISALIGN_CHK_EN.
module im_resp_reg
  import riscv_pkg::*;
#(
  parameter int unsigned AW = IM_AW,
  parameter int unsigned DW = IM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          ready,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  output logic          valid,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data
`ifdef MISALIGN_CHK_EN
  ,
  output logic          err
`endif
);

`ifdef MISALIGN_CHK_EN
  logic misaligned;
  assign misaligned = |load_addr[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (load) begin
      err <= misaligned;
    end
  end
`endif

  // A load in the same cycle as a drain wins, so the register refills back-to-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
`ifdef MISALIGN_CHK_EN
      data  <= misaligned ? DW'(NOP_INSTR) : load_data;
`else
      data  <= load_data;
`endif
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/im_fetch_arbiter.sv
// Arbitrates the single combinational instruction memory between fetch (F) and debug (D).
// Fetch has priority; a starvation counter forces D through after MAX_WAIT denials. MISALIGN_CHK_EN adds err outputs.
module im_fetch_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned AW       = IM_AW,
  parameter int unsigned DW       = IM_DW,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req_valid,
  input  logic [AW-1:0] f_req_addr,
  output logic          f_req_ready,
  output logic          f_resp_valid,
  output logic [DW-1:0] f_resp_data,
  output logic [AW-1:0] f_resp_addr,
  input  logic          f_resp_ready,
  input  logic          d_req_valid,
  input  logic [AW-1:0] d_req_addr,
  output logic          d_req_ready,
  output logic          d_resp_valid,
  output logic [DW-1:0] d_resp_data,
  output logic [AW-1:0] d_resp_addr,
  input  logic          d_resp_ready,
  output logic [AW-1:0] im_addr,
  input  logic [DW-1:0] im_rdata
`ifdef MISALIGN_CHK_EN
  ,
  output logic          f_resp_err,
  output logic          d_resp_err
`endif
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  logic          f_elig;
  logic          d_elig;
  logic [1:0]    gnt;
  logic [CW-1:0] cnt;
  logic          cnt_sat;

  assign f_elig  = f_req_valid && (!f_resp_valid || f_resp_ready);
  assign d_elig  = d_req_valid && (!d_resp_valid || d_resp_ready);
  assign cnt_sat = (cnt == CW'(MAX_WAIT));

  // Fixed priority to F unless D has been denied MAX_WAIT times in a row.
  always_comb begin
    gnt     = 2'b00;
    im_addr = '0;
    if (d_elig && (!f_elig || cnt_sat)) begin
      gnt[PORT_D] = 1'b1;
      im_addr     = d_req_addr;
    end else if (f_elig) begin
      gnt[PORT_F] = 1'b1;
      im_addr     = f_req_addr;
    end
  end

  assign f_req_ready = gnt[PORT_F];
  assign d_req_ready = gnt[PORT_D];

  // Counts consecutive cycles D was eligible but lost to F.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (gnt[PORT_D]) begin
      cnt <= '0;
    end else if (d_elig && gnt[PORT_F] && !cnt_sat) begin
      cnt <= cnt + CW'(1);
    end
  end

  im_resp_reg #(.AW(AW), .DW(DW)) u_f_resp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (gnt[PORT_F]),
    .ready     (f_resp_ready),
    .load_addr (f_req_addr),
    .load_data (im_rdata),
    .valid     (f_resp_valid),
    .addr      (f_resp_addr),
    .data      (f_resp_data)
`ifdef MISALIGN_CHK_EN
    ,
    .err       (f_resp_err)
`endif
  );

  im_resp_reg #(.AW(AW), .DW(DW)) u_d_resp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (gnt[PORT_D]),
    .ready     (d_resp_ready),
    .load_addr (d_req_addr),
    .load_data (im_rdata),
    .valid     (d_resp_valid),
    .addr      (d_resp_addr),
    .data      (d_resp_data)
`ifdef MISALIGN_CHK_EN
    ,
    .err       (d_resp_err)
`endif
  );

endmodule

// File: doc/im_fetch_arbiter.md
Name: im_fetch_arbiter

Overview:
- Shares the single combinational-read instruction memory between two requesters: the core fetch stage (port F) and a debug/loader read port (port D).
- Sits between the PC/fetch logic and the instruction memory. It drives the memory byte address, captures the returned word in a per-port response register, and presents it with a valid/ready handshake.
- Fetch has fixed priority. A starvation counter guarantees port D is served within a bounded time.

Parameters:
- AW, 32, byte-address width (matches memory address input)
- DW, 32, instruction word width
- MAX_WAIT, 4, maximum consecutive cycles D may be eligible and denied before it is forced to win
- CW, $clog2(MAX_WAIT+1), starvation counter width (derived; not overridden)

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- f_req_valid  in  1  fetch request present
- f_req_addr  in  AW  fetch byte address
- f_req_ready  out  1  fetch request accepted this cycle
- f_resp_valid  out  1  fetch response held
- f_resp_data  out  DW  fetched instruction
- f_resp_addr  out  AW  address of f_resp_data
- f_resp_ready  in  1  fetch consumer takes response
- d_req_valid, d_req_addr, d_req_ready, d_resp_valid, d_resp_data, d_resp_addr, d_resp_ready: same as the f_ set, for the debug port
- im_addr  out  AW  byte address to instruction memory (combinational)
- im_rdata  in  DW  word from instruction memory (combinational, same cycle)
- f_resp_err, d_resp_err  out  1  present only with MISALIGN_CHK_EN

Behaviour:
- Clocking: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all *_resp_valid=0, *_resp_data=0, *_resp_addr=0, starvation counter=0, *_resp_err=0.
- Reset asserted mid-operation drops held responses immediately. There is no replay.
- Eligibility per port X: X_req_valid && (!X_resp_valid || X_resp_ready). A response register may be refilled in the same cycle it drains.
- Arbitration (combinational, every cycle):
  - D wins if D is eligible and (F is not eligible, or cnt==MAX_WAIT).
  - Otherwise F wins if F is eligible.
  - Otherwise there is no grant.
- X_req_ready = grant to X. The ready signals are mutually exclusive. A request completes when valid && ready are high on the same edge.
- Memory address: im_addr = granted port's address. With no grant, im_addr = 0.
- Latency: exactly 1 cycle. At the edge of a grant, the granted port loads resp_data=im_rdata and resp_addr=req_addr, and resp_valid goes to 1.
- Response release: resp_valid clears on resp_valid && resp_ready with no new grant to that port. Data and address hold until replaced.
- Response stability: held responses are stable while resp_valid && !resp_ready.
- Starvation counter:
  - Increments (saturating at MAX_WAIT) when D is eligible and F is granted.
  - Clears to 0 when D is granted.
  - Holds when D is not eligible.
- Back-to-back fetch throughput: 1 word/cycle when f_resp_ready is held high.
- Address arithmetic: no translation. The memory applies the >>2 word index itself; this block passes byte addresses unchanged.
- Memory bounds: out-of-range words return whatever the memory yields. Range checking is not this block's job.
- Internal flow control: req_ready never depends on X_req_valid of the same port combinationally, except through eligibility.

Optional Feature:
MISALIGN_CHK_EN
- Defined:
  - Adds f_resp_err and d_resp_err, loaded alongside resp_data.
  - err=1 when req_addr[1:0]!=0 at grant.
  - resp_data is then forced to 32'h00000013 (NOP) instead of im_rdata.
  - err has the same valid/hold rules as data.
- Undefined: err ports are absent. Low address bits are ignored and im_rdata is passed through.

Decomposition:
- Shared package (riscv_pkg), holding:
  - IM_AW=32, IM_DW=32
  - NOP_INSTR=32'h00000013
  - localparam port indices PORT_F=0, PORT_D=1
  - a response struct (valid, addr, data, err)
- One natural sub-module, im_resp_reg: a per-port response holding register with load/drain logic and the optional err bit. It is instantiated twice. Arbitration and the counter stay in the top module.

Test Plan:
- Reset: hold rst_n=0, then release with no requests -> all resp_valid=0, im_addr=0, no ready asserted.
- Fetch stream with memory preloaded with mem[0..3]=32'h00500093, 32'h00a00113, 32'h002081b3, 32'h00000013:
  - Drive f_req_addr 0,4,8,12 on consecutive cycles with f_resp_ready=1.
  - Required: f_req_ready=1 each cycle, and f_resp_data appears 1 cycle later in order with matching f_resp_addr.
- Starvation with MAX_WAIT=4:
  - F and D are valid continuously, both resp_ready=1, D addr=8.
  - Required: F is granted 4 cycles, then D is granted on the 5th cycle with d_resp_data=32'h002081b3 the next cycle, then the counter returns to 0.
- Backpressure:
  - Grant F at addr 4, then hold f_resp_ready=0 for 3 cycles while f_req_valid=1 at addr 8.
  - Required: f_req_ready=0 during the hold, and f_resp_data stays 32'h00a00113.
  - Then raise f_resp_ready -> addr 8 is granted in that same cycle.
- Async reset mid-stream: pulse rst_n low between edges while d_resp_valid=1 -> d_resp_valid drops immediately without a clock edge, and the counter is 0.
- With MISALIGN_CHK_EN: fetch addr 6 -> f_resp_err=1 and f_resp_data=32'h00000013. Addr 4 -> err=0 with normal data.
